// File: rtl/iomem_dma.sv
// iomem_dma: iomem bus-initiator word copy engine (read src, write dst).
// Optional wait-state abort is built when IOMEM_DMA_TIMEOUT_EN is defined.
module iomem_dma #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic             src_inc,
  input  logic             dst_inc,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             iomem_valid,
  input  logic             iomem_ready,
  output logic [3:0]       iomem_wstrb,
  output logic [31:0]      iomem_addr,
  output logic [31:0]      iomem_wdata,
  input  logic [31:0]      iomem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_FIN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:2]      src_q;
  logic [31:2]      dst_q;
  logic [31:0]      data_q;
  logic             src_inc_q;
  logic             dst_inc_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] words_q;
  logic             abort;
  logic             accept;

  // Byte-lane bits of the addresses carry no meaning for word copies.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  assign accept = (state_q == S_IDLE) && start;

`ifdef IOMEM_DMA_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

  logic [CW-1:0] wait_q;
  logic          err_q;

  // Count stalled request cycles; any non-stalled cycle restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else if (iomem_valid && !iomem_ready) begin
      wait_q <= wait_q + 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  // Abort on the edge that closes the TIMEOUT-th stalled cycle.
  assign abort = iomem_valid && !iomem_ready &&
                 (wait_q == CW'(TIMEOUT - 1));

  // Sticky error flag, cleared only by an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign abort = 1'b0;
  assign error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and bus request drive.
  always_comb begin
    state_d     = state_q;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        iomem_valid = 1'b1;
        iomem_addr  = {src_q, 2'b00};
        if (abort) begin
          state_d = S_FIN;
        end else if (iomem_ready) begin
          state_d = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        state_d = S_WR;
      end
      S_WR: begin
        iomem_valid = 1'b1;
        iomem_wstrb = 4'hF;
        iomem_addr  = {dst_q, 2'b00};
        iomem_wdata = data_q;
        if (abort) begin
          state_d = S_FIN;
        end else if (iomem_ready) begin
          state_d = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        state_d = (words_q == len_q) ? S_FIN : S_RD;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transfer context: addresses, data word and progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      len_q     <= '0;
      words_q   <= '0;
    end else begin
      if (accept) begin
        src_q     <= src_addr[31:2];
        dst_q     <= dst_addr[31:2];
        src_inc_q <= src_inc;
        dst_inc_q <= dst_inc;
        len_q     <= len;
        words_q   <= '0;
      end
      if (state_q == S_RD && iomem_ready) begin
        data_q <= iomem_rdata;
        if (src_inc_q) begin
          src_q <= src_q + 30'd1;
        end
      end
      if (state_q == S_WR && iomem_ready) begin
        words_q <= words_q + 1'b1;
        if (dst_inc_q) begin
          dst_q <= dst_q + 30'd1;
        end
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign words_done = words_q;

endmodule
